mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
Two-requester read arbiter sharing the single memory read port between the icache refill port and the dcache/LSU read port. Sits between the caches' `cache_ar_*`/`cache_r_*` miss interfaces and the memory/bus bridge. Single-beat, one-outstanding, round-robin on contention.

Parameters:
ADDR_WIDTH, 32, width of all read addresses
DATA_WIDTH, 64, width of read data

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
i_ar_valid  in  1  icache read request valid
i_ar_ready  out  1  icache request accepted
i_ar_addr  in  ADDR_WIDTH  icache read address
i_r_valid  out  1  icache read data valid
i_r_ready  in  1  icache ready for data
d_ar_valid  in  1  dcache read request valid
d_ar_ready  out  1  dcache request accepted
d_ar_addr  in  ADDR_WIDTH  dcache read address
d_r_valid  out  1  dcache read data valid
d_r_ready  in  1  dcache ready for data
s_r_data  out  DATA_WIDTH  read data, shared to both requesters
s_r_resp  out  2  read response, shared to both requesters
m_ar_valid  out  1  memory read request valid
m_ar_ready  in  1  memory accepts request
m_ar_addr  out  ADDR_WIDTH  memory read address
m_r_valid  in  1  memory read data valid
m_r_ready  out  1  arbiter ready for memory data
m_r_resp  in  2  memory read response
m_r_data  in  DATA_WIDTH  memory read data
grant_o  out  2  owner, one-hot: 01 = icache, 10 = dcache, 00 = none

Behaviour:
- Reset (`rst` low, asynchronous), registered state cleared:
  - state = S_IDLE, owner = none, last_grant = icache.
  - `m_ar_valid` = 0, `m_ar_addr` = 0.
- Reset value of every output:
  - `grant_o` = 00.
  - `i_ar_ready`, `d_ar_ready`, `i_r_valid`, `d_r_valid`, `m_r_ready` = 0.
  - `s_r_data` and `s_r_resp` follow `m_r_data` and `m_r_resp` (combinational).
- States: S_IDLE, S_AR, S_R.
- S_IDLE winner selection (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins. After reset, dcache wins the first tie.
  - `x_ar_ready` = (state == S_IDLE) & winner == x & x_ar_valid. Never asserted outside S_IDLE.
- Accept, on `x_ar_valid` & `x_ar_ready`:
  - Latch the winner's address into `m_ar_addr`.
  - owner = x, `grant_o` = owner one-hot.
  - `m_ar_valid` <= 1, next state S_AR.
- S_AR:
  - `m_ar_valid` and `m_ar_addr` are held stable until `m_ar_ready`.
  - On handshake: `m_ar_valid` <= 0, next state S_R.
- S_R (combinational passthrough):
  - `m_r_ready` = owner's `r_ready`.
  - Owner's `r_valid` = `m_r_valid`; the non-owner's `r_valid` = 0.
- Read completion, on `m_r_valid` & `m_r_ready`:
  - last_grant <= owner, owner <= none, next state S_IDLE.
- Response handling:
  - `m_r_resp` is passed unchanged, including error codes.
  - No retry, no buffering.
- Latency:
  - Accept at cycle T; `m_ar_valid` high at T+1.
  - Earliest data handshake at T+2.
  - Next accept possible the cycle after the data handshake.
- Requester rules:
  - Requesters hold valid and address until ready.
  - A requester deasserting valid before ready is legal while not granted; it is never latched.
  - A new request from the same requester in S_AR/S_R waits in S_IDLE arbitration.
- Non-owner isolation: non-owner requests during S_AR/S_R see ready = 0 and are never lost.
- Reset mid-transaction: the arbiter returns to S_IDLE immediately and the outstanding memory read is abandoned. The memory side shares `rst`.
- Fairness: under continuous contention grants alternate strictly, D, I, D, I, ...

Test Plan:
- icache alone: i_ar_addr = 0x8000_0010, memory ready same cycle, returns data 0x1122_3344_5566_7788 with resp 0 two cycles later → `m_ar_addr` = 0x8000_0010, `i_r_valid` carries the data, `d_r_valid` stays 0, `grant_o` = 01 then 00.
- Simultaneous first requests: i 0x100, d 0x200 → dcache granted first (`m_ar_addr` 0x200); after completion icache granted (0x100).
- Continuous contention for 6 transactions → grant sequence D, I, D, I, D, I.
- Backpressure: hold `m_ar_ready` = 0 for 3 cycles and `i_r_ready` = 0 for 2 cycles after `m_r_valid` → `m_ar_valid`/`m_ar_addr` stable, `m_r_ready` = 0 until `i_r_ready`, no duplicate grant.
- Error response: dcache read returns resp 2'b10 → `s_r_resp` = 2'b10 with `d_r_valid`, arbiter back to S_IDLE.
- Async reset asserted in S_R → all outputs reach reset values without a clock edge; after release, a fresh icache request completes normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Two-requester read arbiter: icache refill and dcache/LSU reads share one
// single-beat memory read port, one transaction outstanding at a time.
// Contention is resolved round-robin against the last completed owner.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no owner; arbitrate and accept one request
// S_AR   | owner's address presented on m_ar_*, waiting for m_ar_ready
// S_R    | address taken; memory data routed straight to the owner
module mem_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_ar_valid,
    output logic                  i_ar_ready,
    input  logic [ADDR_WIDTH-1:0] i_ar_addr,
    output logic                  i_r_valid,
    input  logic                  i_r_ready,

    input  logic                  d_ar_valid,
    output logic                  d_ar_ready,
    input  logic [ADDR_WIDTH-1:0] d_ar_addr,
    output logic                  d_r_valid,
    input  logic                  d_r_ready,

    output logic [DATA_WIDTH-1:0] s_r_data,
    output logic [1:0]            s_r_resp,

    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    input  logic                  m_r_valid,
    output logic                  m_r_ready,
    input  logic [1:0]            m_r_resp,
    input  logic [DATA_WIDTH-1:0] m_r_data,

    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t                state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    // 0 = icache completed last, 1 = dcache completed last
    logic                  last_grant_q, last_grant_d;
    logic                  m_ar_valid_q, m_ar_valid_d;
    logic [ADDR_WIDTH-1:0] m_ar_addr_q, m_ar_addr_d;

    logic                  pick_i, pick_dc;
    logic                  in_r;

    // Arbitration: a lone requester wins; on a tie the one that did not
    // complete last wins (reset value makes dcache win the first tie).
    always_comb begin
        pick_i  = 1'b0;
        pick_dc = 1'b0;
        if (state_q == S_IDLE) begin
            if (i_ar_valid && d_ar_valid) begin
                if (last_grant_q) begin
                    pick_i = 1'b1;
                end else begin
                    pick_dc = 1'b1;
                end
            end else if (i_ar_valid) begin
                pick_i = 1'b1;
            end else if (d_ar_valid) begin
                pick_dc = 1'b1;
            end
        end
    end

    assign i_ar_ready = pick_i;
    assign d_ar_ready = pick_dc;

    // Read data path is a pure passthrough to whichever requester owns the port.
    assign in_r      = (state_q == S_R);
    assign m_r_ready = in_r & ((owner_q[0] & i_r_ready) | (owner_q[1] & d_r_ready));
    assign i_r_valid = in_r & owner_q[0] & m_r_valid;
    assign d_r_valid = in_r & owner_q[1] & m_r_valid;
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;

    assign m_ar_valid = m_ar_valid_q;
    assign m_ar_addr  = m_ar_addr_q;
    assign grant_o    = owner_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        m_ar_valid_d = m_ar_valid_q;
        m_ar_addr_d  = m_ar_addr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_i || pick_dc) begin
                    state_d      = S_AR;
                    owner_d      = pick_dc ? OWN_D : OWN_I;
                    m_ar_valid_d = 1'b1;
                    m_ar_addr_d  = pick_dc ? d_ar_addr : i_ar_addr;
                end
            end
            S_AR: begin
                if (m_ar_ready) begin
                    m_ar_valid_d = 1'b0;
                    state_d      = S_R;
                end
            end
            S_R: begin
                if (m_r_valid && m_r_ready) begin
                    last_grant_d = owner_q[1];
                    owner_d      = OWN_NONE;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                owner_d      = OWN_NONE;
                m_ar_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any in-flight memory read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            last_grant_q <= 1'b0;
            m_ar_valid_q <= 1'b0;
            m_ar_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            m_ar_valid_q <= m_ar_valid_d;
            m_ar_addr_q  <= m_ar_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: transaction-level reference model checked every
// cycle, bus-functional requesters and memory, directed scenarios with
// literal expectations, then a randomized soak.
module tb_mem_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          i_ar_valid, i_ar_ready, i_r_valid, i_r_ready;
    logic [AW-1:0] i_ar_addr;
    logic          d_ar_valid, d_ar_ready, d_r_valid, d_r_ready;
    logic [AW-1:0] d_ar_addr;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_resp;
    logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW-1:0] m_ar_addr;
    logic [1:0]    m_r_resp;
    logic [DW-1:0] m_r_data;
    logic [1:0]    grant_o;

    mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_ar_valid(i_ar_valid), .i_ar_ready(i_ar_ready), .i_ar_addr(i_ar_addr),
        .i_r_valid(i_r_valid), .i_r_ready(i_r_ready),
        .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_addr(d_ar_addr),
        .d_r_valid(d_r_valid), .d_r_ready(d_r_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_resp(m_r_resp),
        .m_r_data(m_r_data), .grant_o(grant_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: is a read in flight, who owns it, has its
    // address been taken by memory, and who finished last.
    bit            md_busy;
    bit            md_sent;
    int            md_owner;
    int            md_last;
    logic [AW-1:0] md_addr;

    task automatic model_reset();
        md_busy  = 1'b0;
        md_sent  = 1'b0;
        md_owner = 0;
        md_last  = 0;
        md_addr  = '0;
    endtask

    task automatic model_step();
        int            win;
        bit            own_rr;
        bit            data_phase;
        bit            e_mrr;
        logic [1:0]    e_grant;
        win = -1;
        if (!md_busy) begin
            if (i_ar_valid && d_ar_valid) win = (md_last == 0) ? 1 : 0;
            else if (i_ar_valid)          win = 0;
            else if (d_ar_valid)          win = 1;
        end
        data_phase = md_busy && md_sent;
        own_rr     = (md_owner == 1) ? d_r_ready : i_r_ready;
        e_mrr      = data_phase && own_rr;
        e_grant    = !md_busy ? 2'b00 : ((md_owner == 1) ? 2'b10 : 2'b01);
        chk("mdl_i_ar_ready", i_ar_ready, (win == 0));
        chk("mdl_d_ar_ready", d_ar_ready, (win == 1));
        chk("mdl_m_ar_valid", m_ar_valid, (md_busy && !md_sent));
        chk("mdl_m_ar_addr", m_ar_addr, md_addr);
        chk("mdl_m_r_ready", m_r_ready, e_mrr);
        chk("mdl_i_r_valid", i_r_valid, (data_phase && md_owner == 0 && m_r_valid));
        chk("mdl_d_r_valid", d_r_valid, (data_phase && md_owner == 1 && m_r_valid));
        chk("mdl_grant", grant_o, e_grant);
        chk("mdl_s_r_data", s_r_data, m_r_data);
        chk("mdl_s_r_resp", s_r_resp, m_r_resp);
        if (win >= 0) begin
            md_busy  = 1'b1;
            md_sent  = 1'b0;
            md_owner = win;
            md_addr  = (win == 1) ? d_ar_addr : i_ar_addr;
        end else if (md_busy && !md_sent && m_ar_ready) begin
            md_sent = 1'b1;
        end else if (data_phase && m_r_valid && e_mrr) begin
            md_busy = 1'b0;
            md_last = md_owner;
        end
    endtask

    // Bus-functional peers.
    bit            manual;
    bit            mem_fast;
    bit            req_drop;
    int            req_prob;
    int            rready_prob;
    bit            rq_v [2];
    logic [AW-1:0] rq_a [2];
    bit            rq_rr[2];
    bit            out_v[2];
    logic [AW-1:0] out_a[2];
    bit            mem_pend;
    bit            mem_rv;
    logic [AW-1:0] mem_addr;
    int            done_cnt;
    int            glog[$];
    logic [AW-1:0] alog[$];

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a};
    endfunction

    function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
        return a[3:2];
    endfunction

    task automatic peers_clear();
        for (int k = 0; k < 2; k++) begin
            rq_v[k]  = 1'b0;
            rq_a[k]  = '0;
            rq_rr[k] = 1'b0;
            out_v[k] = 1'b0;
            out_a[k] = '0;
        end
        mem_pend = 1'b0;
        mem_rv   = 1'b0;
        mem_addr = '0;
    endtask

    task automatic idle_inputs();
        i_ar_valid = 1'b0; i_ar_addr = '0; i_r_ready = 1'b0;
        d_ar_valid = 1'b0; d_ar_addr = '0; d_r_ready = 1'b0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_resp = 2'b00; m_r_data = '0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 2; k++) begin
            if (!rq_v[k]) begin
                if (int'($urandom_range(99)) < req_prob) begin
                    rq_v[k] = 1'b1;
                    rq_a[k] = $urandom & 32'hFFFF_FFF8;
                end
            end else if (req_drop && $urandom_range(7) == 0) begin
                rq_v[k] = 1'b0;
            end
            rq_rr[k] = (int'($urandom_range(99)) < rready_prob);
        end
        i_ar_valid = rq_v[0]; i_ar_addr = rq_a[0]; i_r_ready = rq_rr[0];
        d_ar_valid = rq_v[1]; d_ar_addr = rq_a[1]; d_r_ready = rq_rr[1];
        m_ar_ready = mem_fast ? 1'b1 : 1'($urandom_range(1));
        if (mem_pend && !mem_rv && (mem_fast || $urandom_range(2) == 0)) mem_rv = 1'b1;
        m_r_valid = mem_rv;
        if (mem_rv) begin
            m_r_data = mem_data(mem_addr);
            m_r_resp = mem_resp(mem_addr);
        end else begin
            m_r_data = {$urandom, $urandom};
            m_r_resp = 2'($urandom_range(3));
        end
    endtask

    task automatic update_peers();
        string pref;
        bit    arr, rv;
        if (m_r_valid && m_r_ready) begin
            mem_pend = 1'b0;
            mem_rv   = 1'b0;
        end
        if (m_ar_valid && m_ar_ready) begin
            mem_pend = 1'b1;
            mem_addr = m_ar_addr;
            alog.push_back(m_ar_addr);
        end
        for (int k = 0; k < 2; k++) begin
            pref = (k == 1) ? "d" : "i";
            arr  = (k == 1) ? d_ar_ready : i_ar_ready;
            rv   = (k == 1) ? d_r_valid : i_r_valid;
            if (rv && rq_rr[k]) begin
                chk({pref, "_rd_expected"}, out_v[k], 1'b1);
                chk({pref, "_rd_data"}, s_r_data, mem_data(out_a[k]));
                chk({pref, "_rd_resp"}, s_r_resp, mem_resp(out_a[k]));
                out_v[k] = 1'b0;
                done_cnt++;
            end
            if (rq_v[k] && arr) begin
                out_v[k] = 1'b1;
                out_a[k] = rq_a[k];
                rq_v[k]  = 1'b0;
                glog.push_back(k);
            end
        end
    endtask

    task automatic settle();
        #1;
        model_step();
        if (!manual) update_peers();
    endtask

    task automatic cycle();
        if (!manual) drive_inputs();
        settle();
        @(negedge clk);
    endtask

    task automatic auto_mode(input bit fast, input int rp, input bit drop, input int rrp);
        manual      = 1'b0;
        mem_fast    = fast;
        req_prob    = rp;
        req_drop    = drop;
        rready_prob = rrp;
    endtask

    initial begin
        manual = 1'b1;
        mem_fast = 1'b1; req_prob = 0; req_drop = 1'b0; rready_prob = 100;
        done_cnt = 0;
        peers_clear();
        model_reset();
        rst = 1'b0;
        idle_inputs();
        m_r_data = 64'h0123_4567_89AB_CDEF;
        m_r_resp = 2'b11;
        #2;
        chk("rst0_grant", grant_o, 2'b00);
        chk("rst0_i_ar_ready", i_ar_ready, 1'b0);
        chk("rst0_d_ar_ready", d_ar_ready, 1'b0);
        chk("rst0_i_r_valid", i_r_valid, 1'b0);
        chk("rst0_d_r_valid", d_r_valid, 1'b0);
        chk("rst0_m_r_ready", m_r_ready, 1'b0);
        chk("rst0_m_ar_valid", m_ar_valid, 1'b0);
        chk("rst0_m_ar_addr", m_ar_addr, 32'h0);
        chk("rst0_s_r_data", s_r_data, 64'h0123_4567_89AB_CDEF);
        chk("rst0_s_r_resp", s_r_resp, 2'b11);
        @(negedge clk);
        rst = 1'b1;

        // First tie after reset goes to dcache, then icache.
        auto_mode(1'b1, 0, 1'b0, 100);
        rq_v[0] = 1'b1; rq_a[0] = 32'h0000_0100;
        rq_v[1] = 1'b1; rq_a[1] = 32'h0000_0200;
        alog.delete(); glog.delete(); done_cnt = 0;
        for (int k = 0; k < 30 && done_cnt < 2; k++) cycle();
        chk("tie_done", done_cnt, 2);
        chk("tie_ar_count", alog.size(), 2);
        if (alog.size() >= 2) begin
            chk("tie_first_addr", alog[0], 32'h0000_0200);
            chk("tie_second_addr", alog[1], 32'h0000_0100);
        end

        // icache alone, memory ready immediately, data two cycles after accept.
        manual = 1'b1;
        idle_inputs();
        i_ar_valid = 1'b1; i_ar_addr = 32'h8000_0010; m_ar_ready = 1'b1; i_r_ready = 1'b1;
        settle();
        chk("solo_ar_ready", i_ar_ready, 1'b1);
        chk("solo_grant_pre", grant_o, 2'b00);
        @(negedge clk);
        i_ar_valid = 1'b0; i_ar_addr = '0;
        settle();
        chk("solo_m_ar_valid", m_ar_valid, 1'b1);
        chk("solo_m_ar_addr", m_ar_addr, 32'h8000_0010);
        chk("solo_grant", grant_o, 2'b01);
        @(negedge clk);
        m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 64'h1122_3344_5566_7788; m_r_resp = 2'b00;
        settle();
        chk("solo_i_r_valid", i_r_valid, 1'b1);
        chk("solo_d_r_valid", d_r_valid, 1'b0);
        chk("solo_s_r_data", s_r_data, 64'h1122_3344_5566_7788);
        chk("solo_m_r_ready", m_r_ready, 1'b1);
        @(negedge clk);
        m_r_valid = 1'b0;
        settle();
        chk("solo_grant_post", grant_o, 2'b00);
        @(negedge clk);

        // Continuous contention: last owner was icache, so D, I, D, I, D, I.
        peers_clear();
        auto_mode(1'b1, 100, 1'b0, 100);
        glog.delete();
        for (int k = 0; k < 80 && glog.size() < 6; k++) cycle();
        chk("cont_count", glog.size(), 6);
        for (int k = 0; k < glog.size() && k < 6; k++)
            chk($sformatf("cont_grant%0d", k), glog[k], (k % 2 == 0) ? 1 : 0);
        req_prob = 0;
        for (int k = 0; k < 60 && (rq_v[0] || rq_v[1] || out_v[0] || out_v[1] || mem_pend); k++)
            cycle();
        chk("cont_drain", (rq_v[0] || rq_v[1] || out_v[0] || out_v[1] || mem_pend), 1'b0);

        // Backpressure on both memory channels, non-owner held off meanwhile.
        manual = 1'b1;
        idle_inputs();
        i_ar_valid = 1'b1; i_ar_addr = 32'h0000_4440;
        settle();
        chk("bp_accept", i_ar_ready, 1'b1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            i_ar_valid = 1'b0; d_ar_valid = 1'b1; d_ar_addr = 32'h0000_0308; m_ar_ready = 1'b0;
            settle();
            chk($sformatf("bp_m_ar_valid%0d", j), m_ar_valid, 1'b1);
            chk($sformatf("bp_m_ar_addr%0d", j), m_ar_addr, 32'h0000_4440);
            chk($sformatf("bp_d_held%0d", j), d_ar_ready, 1'b0);
            chk($sformatf("bp_grant%0d", j), grant_o, 2'b01);
            @(negedge clk);
        end
        m_ar_ready = 1'b1;
        settle();
        chk("bp_ar_hs_addr", m_ar_addr, 32'h0000_4440);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 64'h0BAD_F00D_1234_5678;
            m_r_resp = 2'b01; i_r_ready = 1'b0;
            settle();
            chk($sformatf("bp_i_r_valid%0d", j), i_r_valid, 1'b1);
            chk($sformatf("bp_m_r_ready%0d", j), m_r_ready, 1'b0);
            chk($sformatf("bp_d_ar_ready%0d", j), d_ar_ready, 1'b0);
            @(negedge clk);
        end
        i_r_ready = 1'b1;
        settle();
        chk("bp_m_r_ready_rel", m_r_ready, 1'b1);
        chk("bp_s_r_data", s_r_data, 64'h0BAD_F00D_1234_5678);
        @(negedge clk);
        m_r_valid = 1'b0; i_r_ready = 1'b0;
        settle();
        chk("bp_idle_grant", grant_o, 2'b00);
        chk("bp_d_wins", d_ar_ready, 1'b1);
        chk("bp_no_dup", i_ar_ready, 1'b0);
        @(negedge clk);

        // dcache read returning an error response.
        d_ar_valid = 1'b0; m_ar_ready = 1'b1;
        settle();
        chk("err_m_ar_addr", m_ar_addr, 32'h0000_0308);
        chk("err_grant", grant_o, 2'b10);
        @(negedge clk);
        m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_resp = 2'b10;
        m_r_data = 64'hCAFE_0000_BEEF_0001; d_r_ready = 1'b1;
        settle();
        chk("err_d_r_valid", d_r_valid, 1'b1);
        chk("err_i_r_valid", i_r_valid, 1'b0);
        chk("err_s_r_resp", s_r_resp, 2'b10);
        chk("err_m_r_ready", m_r_ready, 1'b1);
        @(negedge clk);
        m_r_valid = 1'b0; d_r_ready = 1'b0; i_ar_valid = 1'b1; i_ar_addr = 32'h0000_7770;
        settle();
        chk("err_back_idle", i_ar_ready, 1'b1);
        chk("err_grant_post", grant_o, 2'b00);
        @(negedge clk);

        // Asynchronous reset while the icache read sits in the data phase.
        i_ar_valid = 1'b0; m_ar_ready = 1'b1;
        settle();
        chk("ar_grant", grant_o, 2'b01);
        @(negedge clk);
        m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 64'h5555_AAAA_5555_AAAA;
        m_r_resp = 2'b00; i_r_ready = 1'b1;
        settle();
        chk("ar_pre_i_r_valid", i_r_valid, 1'b1);
        chk("ar_pre_m_r_ready", m_r_ready, 1'b1);
        rst = 1'b0;
        #1;
        chk("ar_grant_rst", grant_o, 2'b00);
        chk("ar_m_ar_valid_rst", m_ar_valid, 1'b0);
        chk("ar_m_ar_addr_rst", m_ar_addr, 32'h0);
        chk("ar_i_r_valid_rst", i_r_valid, 1'b0);
        chk("ar_m_r_ready_rst", m_r_ready, 1'b0);
        chk("ar_s_r_data_rst", s_r_data, 64'h5555_AAAA_5555_AAAA);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        peers_clear();
        auto_mode(1'b1, 0, 1'b0, 100);
        rq_v[0] = 1'b1; rq_a[0] = 32'h0000_ABC0;
        done_cnt = 0; alog.delete();
        for (int k = 0; k < 20 && done_cnt < 1; k++) cycle();
        chk("post_rst_done", done_cnt, 1);
        if (alog.size() > 0) chk("post_rst_addr", alog[0], 32'h0000_ABC0);

        // Randomized soak with backpressure and abandoned requests.
        auto_mode(1'b0, 30, 1'b1, 60);
        done_cnt = 0;
        for (int k = 0; k < 3000; k++) cycle();
        chk("rand_progress", (done_cnt >= 50), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
